// File: rtl/seq_chunk_adder_if.sv
// Start/busy/done handshake bundle between a controller and seq_chunk_adder.
interface seq_chunk_adder_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             V;

  modport master (
    output start, A, B, Cin, sub,
    input  busy, done, S, Cout, V
  );

  modport slave (
    input  start, A, B, Cin, sub,
    output busy, done, S, Cout, V
  );
endinterface

// File: rtl/seq_chunk_adder.sv
// Multi-cycle add/subtract: CHUNK bits per clock with a registered inter-chunk carry.
// WIDTH >= 2 and CHUNK must divide WIDTH.
module seq_chunk_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 1
) (
  input  logic clk,
  input  logic rst,
  seq_chunk_adder_if.slave bus
);
  localparam int unsigned NCH  = WIDTH / CHUNK;
  localparam int unsigned IDXW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned CW   = CHUNK + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_n;
  logic [WIDTH-1:0]  op_a, op_a_n;
  logic [WIDTH-1:0]  op_b, op_b_n;
  logic [WIDTH-1:0]  res, res_n;
  logic [WIDTH-1:0]  s_q, s_n;
  logic [IDXW-1:0]   idx, idx_n;
  logic              carry, carry_n;
  logic              cout_q, cout_n;
  logic              v_q, v_n;
  logic              busy_q, busy_n;
  logic              done_q, done_n;

  logic [CHUNK-1:0]  a_ch, b_ch;
  logic [CW-1:0]     sum;
  logic              cin_msb;

  // Current chunk slice and its ripple; the carry into the chunk MSB is
  // recovered from sum = a ^ b ^ cin at that bit.
  always_comb begin
    a_ch    = op_a[idx*CHUNK +: CHUNK];
    b_ch    = op_b[idx*CHUNK +: CHUNK];
    sum     = CW'(a_ch) + CW'(b_ch) + CW'(carry);
    cin_msb = sum[CHUNK-1] ^ a_ch[CHUNK-1] ^ b_ch[CHUNK-1];
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n = state;
    op_a_n  = op_a;
    op_b_n  = op_b;
    res_n   = res;
    s_n     = s_q;
    idx_n   = idx;
    carry_n = carry;
    cout_n  = cout_q;
    v_n     = v_q;

    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          op_a_n  = bus.A;
          op_b_n  = bus.sub ? ~bus.B : bus.B;
          carry_n = bus.Cin ^ bus.sub;
          idx_n   = '0;
          state_n = RUN;
        end else begin
          state_n = IDLE;
        end
      end
      RUN: begin
        res_n[idx*CHUNK +: CHUNK] = sum[CHUNK-1:0];
        carry_n = sum[CHUNK];
        idx_n   = idx + IDXW'(1);
        if (idx == IDXW'(NCH - 1)) begin
          s_n     = res_n;
          cout_n  = sum[CHUNK];
          v_n     = cin_msb ^ sum[CHUNK];
          idx_n   = '0;
          state_n = DONE;
        end
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n == RUN);
    done_n = (state_n == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      op_a   <= '0;
      op_b   <= '0;
      res    <= '0;
      s_q    <= '0;
      idx    <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      v_q    <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      op_a   <= op_a_n;
      op_b   <= op_b_n;
      res    <= res_n;
      s_q    <= s_n;
      idx    <= idx_n;
      carry  <= carry_n;
      cout_q <= cout_n;
      v_q    <= v_n;
      busy_q <= busy_n;
      done_q <= done_n;
    end
  end

  assign bus.S    = s_q;
  assign bus.Cout = cout_q;
  assign bus.V    = v_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed self-checking bench: one CHUNK=1 and one CHUNK=4 instance, WIDTH=8.
module tb_seq_chunk_adder;
  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  seq_chunk_adder_if #(.WIDTH(8)) bus1 ();
  seq_chunk_adder_if #(.WIDTH(8)) bus4 ();

  seq_chunk_adder #(.WIDTH(8), .CHUNK(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  seq_chunk_adder #(.WIDTH(8), .CHUNK(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input int sel, input logic st, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic sb);
    if (sel == 1) begin
      bus1.start = st; bus1.A = a; bus1.B = b; bus1.Cin = cin; bus1.sub = sb;
    end else begin
      bus4.start = st; bus4.A = a; bus4.B = b; bus4.Cin = cin; bus4.sub = sb;
    end
  endtask

  function automatic logic [11:0] get_out(input int sel);
    // {busy, done, Cout, V, S}
    if (sel == 1) return {bus1.busy, bus1.done, bus1.Cout, bus1.V, bus1.S};
    return {bus4.busy, bus4.done, bus4.Cout, bus4.V, bus4.S};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one op, optionally scramble inputs while running, then check
  // latency, result flags, and that S held its old value during RUN.
  task automatic run_op(input int sel, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic sb, input int lat,
                        input logic [7:0] es, input logic ec, input logic ev,
                        input string tag, input bit scramble);
    logic [11:0] o;
    logic [7:0]  prev_s;
    int          cnt;
    int          changes;
    set_in(sel, 1'b1, a, b, cin, sb);
    tick();
    set_in(sel, 1'b0, a, b, cin, sb);
    o = get_out(sel);
    chk({tag, "_busy0"}, 32'(o[11:10]), 32'h2);
    prev_s  = o[7:0];
    cnt     = 0;
    changes = 0;
    while (o[10] !== 1'b1 && cnt < 20) begin
      if (scramble)
        set_in(sel, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      tick();
      cnt++;
      o = get_out(sel);
      if (o[10] !== 1'b1 && o[7:0] !== prev_s) changes++;
    end
    chk({tag, "_lat"},  32'(cnt), 32'(lat));
    chk({tag, "_S"},    32'(o[7:0]), 32'(es));
    chk({tag, "_Cout"}, 32'(o[9]), 32'(ec));
    chk({tag, "_V"},    32'(o[8]), 32'(ev));
    chk({tag, "_bsy"},  32'(o[11]), 32'h0);
    chk({tag, "_hold"}, 32'(changes), 32'h0);
    set_in(sel, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    logic [11:0] o;
    int          cnt;
    int          dones;

    rst = 1'b1;
    set_in(1, 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    set_in(4, 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    tick();
    tick();
    chk("rst_dut1", 32'(get_out(1)), 32'h0);
    chk("rst_dut4", 32'(get_out(4)), 32'h0);
    rst = 1'b0;
    set_in(1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    set_in(4, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    tick();

    // Add, CHUNK=1
    run_op(1, 8'h3C, 8'h0F, 1'b0, 1'b0, 8, 8'h4B, 1'b0, 1'b0, "add_3c0f", 1'b0);
    run_op(1, 8'hFF, 8'h01, 1'b1, 1'b0, 8, 8'h01, 1'b1, 1'b0, "add_ff01", 1'b0);
    run_op(1, 8'h7F, 8'h01, 1'b0, 1'b0, 8, 8'h80, 1'b0, 1'b1, "add_7f01", 1'b0);
    for (int k = 0; k < 8; k++) begin
      logic cin, a0, b0;
      cin = k[2]; a0 = k[1]; b0 = k[0];
      run_op(1, {7'h0, a0}, {7'h0, b0}, cin, 1'b0, 8,
             8'(cin) + 8'(a0) + 8'(b0), 1'b0, 1'b0, $sformatf("fa%0d", k), 1'b0);
    end

    // Subtract, CHUNK=1
    run_op(1, 8'h05, 8'h07, 1'b0, 1'b1, 8, 8'hFE, 1'b0, 1'b0, "sub_0507", 1'b0);
    run_op(1, 8'h80, 8'h01, 1'b0, 1'b1, 8, 8'h7F, 1'b1, 1'b1, "sub_8001", 1'b0);
    run_op(1, 8'h10, 8'h01, 1'b1, 1'b1, 8, 8'h0E, 1'b1, 1'b0, "sub_1001b", 1'b0);

    // CHUNK=4: C8+64 = 0x12C, carry into bit 7 and out of bit 7 both set -> V=0
    run_op(4, 8'hC8, 8'h64, 1'b0, 1'b0, 2, 8'h2C, 1'b1, 1'b0, "c4_c864", 1'b0);
    run_op(4, 8'h7F, 8'h01, 1'b0, 1'b0, 2, 8'h80, 1'b0, 1'b1, "c4_7f01", 1'b0);

    // CHUNK=4: start pulsed while busy is ignored
    set_in(4, 1'b1, 8'h12, 8'h34, 1'b0, 1'b0);
    tick();
    set_in(4, 1'b1, 8'hAA, 8'hAA, 1'b0, 1'b0);
    tick();
    set_in(4, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    tick();
    o = get_out(4);
    chk("ign_done", 32'(o[11:10]), 32'h1);
    chk("ign_S", 32'(o[7:0]), 32'h46);
    dones = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (get_out(4) & 12'h400) dones++;
    end
    chk("ign_single", 32'(dones), 32'h0);
    chk("ign_idle", 32'(get_out(4)), 32'h046);

    // Back-to-back with start held high; operands change after acceptance
    set_in(1, 1'b1, 8'h10, 8'h20, 1'b0, 1'b0);
    tick();
    set_in(1, 1'b1, 8'h01, 8'h01, 1'b0, 1'b0);
    cnt = 0;
    o = get_out(1);
    while (o[10] !== 1'b1 && cnt < 20) begin
      tick();
      cnt++;
      o = get_out(1);
    end
    chk("b2b_lat1", 32'(cnt), 32'h8);
    chk("b2b_S1", 32'(o[7:0]), 32'h30);
    tick();
    set_in(1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    o = get_out(1);
    chk("b2b_acc", 32'(o[11:10]), 32'h2);
    cnt = 0;
    while (o[10] !== 1'b1 && cnt < 20) begin
      tick();
      cnt++;
      o = get_out(1);
    end
    chk("b2b_lat2", 32'(cnt), 32'h8);
    chk("b2b_S2", 32'(o[7:0]), 32'h02);
    tick();

    // Abort in RUN cycle 3
    set_in(1, 1'b1, 8'h11, 8'h22, 1'b0, 1'b0);
    tick();
    set_in(1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_out", 32'(get_out(1)), 32'h0);
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (get_out(1) & 12'h400) dones++;
    end
    chk("abort_nodone", 32'(dones), 32'h0);
    run_op(1, 8'h21, 8'h12, 1'b1, 1'b0, 8, 8'h34, 1'b0, 1'b0, "post_abort", 1'b0);

    // Inputs scrambled every RUN cycle: 5A-33 = 27
    run_op(1, 8'h5A, 8'h33, 1'b0, 1'b1, 8, 8'h27, 1'b1, 1'b0, "stable1", 1'b1);
    run_op(4, 8'h5A, 8'h33, 1'b0, 1'b1, 2, 8'h27, 1'b1, 1'b0, "stable4", 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
